// File: rtl/elevator_scan_ctrl_if.sv
// Call-panel / cabin signal bundle for elevator_scan_ctrl.
// The fire input exists only when FIRE_RECALL_EN is defined.
interface elevator_scan_ctrl_if #(
   parameter int unsigned FLOORS  = 4,
   parameter int unsigned FLOOR_W = 2,
   parameter int unsigned CNT_W   = 3
);
   logic                tick;
   logic [FLOORS-1:0]   call_in;
   logic [FLOORS-1:0]   call_out;
   logic                enter;
   logic                leave;
`ifdef FIRE_RECALL_EN
   logic                fire;
`endif
   logic [FLOOR_W-1:0]  floor;
   logic                dir_up;
   logic                moving;
   logic                door_open;
   logic [FLOORS-1:0]   pending;
   logic [CNT_W-1:0]    occupancy;
   logic                overload;

   modport master (
`ifdef FIRE_RECALL_EN
      output fire,
`endif
      output tick, call_in, call_out, enter, leave,
      input  floor, dir_up, moving, door_open, pending, occupancy, overload
   );

   modport slave (
`ifdef FIRE_RECALL_EN
      input  fire,
`endif
      input  tick, call_in, call_out, enter, leave,
      output floor, dir_up, moving, door_open, pending, occupancy, overload
   );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller with travel/door timers and occupancy tracking.
// Optional fire recall (car to floor 0, door held open) when FIRE_RECALL_EN is defined.
module elevator_scan_ctrl #(
   parameter int unsigned FLOORS       = 4,
   parameter int unsigned FLOOR_W      = 2,
   parameter int unsigned TRAVEL_TICKS = 3,
   parameter int unsigned DOOR_TICKS   = 4,
   parameter int unsigned CAP          = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic               clk,
   input  logic               reset0,
   elevator_scan_ctrl_if.slave bus
);
   localparam int unsigned TRV_W  = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
   localparam int unsigned DOOR_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MOVING, S_DOOR_OPEN} state_t;

   state_t              r_state;
   logic [FLOOR_W-1:0]  r_floor;
   logic                r_dir_up;
   logic                r_moving;
   logic                r_door_open;
   logic [FLOORS-1:0]   r_pending;
   logic [CNT_W-1:0]    r_occ;
   logic                r_overload;
   logic [TRV_W-1:0]    r_trv_cnt;
   logic [DOOR_W-1:0]   r_door_cnt;

   logic                w_fire;
   logic [FLOORS-1:0]   w_call;
   logic [FLOORS-1:0]   w_store;
   logic [FLOORS-1:0]   w_req;
   logic [FLOORS-1:0]   w_here;
   logic [FLOORS-1:0]   w_arr_oh;
   logic [FLOOR_W-1:0]  w_arr_floor;
   logic                w_here_call;
   logic                w_req_here;
   logic                w_req_arr;
   logic                w_door_hold;
   logic [1:0]          w_scan_cur;
   logic [1:0]          w_scan_arr;
   logic [CNT_W-1:0]    w_occ_nxt;

   // Direction pinned at the end floors so the car can never leave 0..FLOORS-1.
   function automatic logic f_bound(input logic [FLOOR_W-1:0] f, input logic d);
      if (f == FLOOR_W'(FLOORS - 1)) return 1'b0;
      if (f == '0)                   return 1'b1;
      return d;
   endfunction

   // SCAN decision with the given floor excluded: {go, next dir_up}.
   function automatic logic [1:0] f_scan(input logic [FLOORS-1:0] m,
                                         input logic [FLOOR_W-1:0] f,
                                         input logic d);
      logic above;
      logic below;
      logic nd;
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < int'(FLOORS); i++) begin
         if (i > int'(f)) above |= m[i];
         if (i < int'(f)) below |= m[i];
      end
      if (d ? above : below) nd = d;
      else if (above | below) nd = ~d;
      else nd = d;
      return {above | below, f_bound(f, nd)};
   endfunction

`ifdef FIRE_RECALL_EN
   assign w_fire = bus.fire;
`else
   assign w_fire = 1'b0;
`endif

   assign w_call      = (bus.call_in | bus.call_out) & {FLOORS{~w_fire}};
   assign w_here      = FLOORS'(1) << r_floor;
   assign w_arr_floor = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
   assign w_arr_oh    = FLOORS'(1) << w_arr_floor;
   // During fire recall floor 0 is the only destination.
   assign w_req       = w_fire ? FLOORS'(1) : r_pending;
   assign w_store     = (r_state == S_MOVING) ? w_call : (w_call & ~w_here);
   assign w_here_call = |(w_call & w_here);
   assign w_req_here  = |(w_req & w_here);
   assign w_req_arr   = |(w_req & w_arr_oh);
   assign w_door_hold = r_overload | (w_fire & (r_floor == '0));
   assign w_scan_cur  = f_scan(w_req, r_floor, r_dir_up);
   assign w_scan_arr  = f_scan(w_req, w_arr_floor, r_dir_up);

   // Occupancy counts only with the door open; saturates at both ends.
   always_comb begin
      w_occ_nxt = r_occ;
      if (r_door_open && bus.enter && !bus.leave && (r_occ != '1))
         w_occ_nxt = r_occ + CNT_W'(1);
      else if (r_door_open && bus.leave && !bus.enter && (r_occ != '0))
         w_occ_nxt = r_occ - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset0) begin
      if (reset0) begin
         r_state     <= S_IDLE;
         r_floor     <= '0;
         r_dir_up    <= 1'b1;
         r_moving    <= 1'b0;
         r_door_open <= 1'b0;
         r_pending   <= '0;
         r_occ       <= '0;
         r_overload  <= 1'b0;
         r_trv_cnt   <= '0;
         r_door_cnt  <= '0;
      end else begin
         r_occ      <= w_occ_nxt;
         r_overload <= (32'(w_occ_nxt) > CAP);
         r_pending  <= (r_pending | w_store) & {FLOORS{~w_fire}};
         case (r_state)
            S_IDLE: begin
               if (w_req_here || w_here_call) begin
                  r_state     <= S_DOOR_OPEN;
                  r_door_open <= 1'b1;
                  r_door_cnt  <= '0;
                  r_pending   <= (r_pending | w_store) & ~w_here & {FLOORS{~w_fire}};
               end else begin
                  r_dir_up <= w_scan_cur[0];
                  if (w_scan_cur[1]) begin
                     r_state   <= S_MOVING;
                     r_moving  <= 1'b1;
                     r_trv_cnt <= '0;
                  end
               end
            end
            S_MOVING: begin
               if (bus.tick) begin
                  if (r_trv_cnt == TRV_W'(TRAVEL_TICKS - 1)) begin
                     r_trv_cnt <= '0;
                     r_floor   <= w_arr_floor;
                     if (w_req_arr) begin
                        r_state     <= S_DOOR_OPEN;
                        r_moving    <= 1'b0;
                        r_door_open <= 1'b1;
                        r_door_cnt  <= '0;
                        r_dir_up    <= f_bound(w_arr_floor, r_dir_up);
                        r_pending   <= (r_pending | w_store) & ~w_arr_oh & {FLOORS{~w_fire}};
                     end else begin
                        r_dir_up <= w_scan_arr[0];
                        if (!w_scan_arr[1]) begin
                           r_state  <= S_IDLE;
                           r_moving <= 1'b0;
                        end
                     end
                  end else begin
                     r_trv_cnt <= r_trv_cnt + TRV_W'(1);
                  end
               end
            end
            S_DOOR_OPEN: begin
               // Activity restarts the countdown; overload (or recall at floor 0) freezes it.
               if (bus.enter || bus.leave || w_here_call || w_door_hold) begin
                  r_door_cnt <= '0;
               end else if (bus.tick) begin
                  if (r_door_cnt == DOOR_W'(DOOR_TICKS - 1)) begin
                     r_door_cnt  <= '0;
                     r_door_open <= 1'b0;
                     r_dir_up    <= w_scan_cur[0];
                     if (w_scan_cur[1]) begin
                        r_state  <= S_MOVING;
                        r_moving <= 1'b1;
                        r_trv_cnt <= '0;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_door_cnt <= r_door_cnt + DOOR_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.floor     = r_floor;
   assign bus.dir_up    = r_dir_up;
   assign bus.moving    = r_moving;
   assign bus.door_open = r_door_open;
   assign bus.pending   = r_pending;
   assign bus.occupancy = r_occ;
   assign bus.overload  = r_overload;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed test-plan scenarios plus random traffic,
// every cycle compared against a behavioural SCAN elevator model.
module tb_elevator_scan_ctrl;
   localparam int FL   = 4;
   localparam int TT   = 3;
   localparam int DT   = 4;
   localparam int CAP  = 4;
   localparam int OMAX = 7;

   logic clk;
   logic reset0;
   int   errors;
   int   checks;
   bit   cmp_en;

   elevator_scan_ctrl_if #(.FLOORS(FL), .FLOOR_W(2), .CNT_W(3)) bus ();

   elevator_scan_ctrl #(
      .FLOORS(FL), .FLOOR_W(2), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .CAP(CAP), .CNT_W(3)
   ) dut (
      .clk(clk), .reset0(reset0), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 = parked, 1 = travelling, 2 = door open.
   logic [FL-1:0] m_pend;
   int            m_floor;
   bit            m_dir;
   int            m_mode;
   int            m_occ;
   bit            m_ovl;
   int            m_tt;
   int            m_dt;

   function automatic bit any_in(input logic [FL-1:0] p, input int lo, input int hi);
      for (int j = lo; j <= hi; j++)
         if (j >= 0 && j < FL && p[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void pick(input logic [FL-1:0] p, input int f, input bit d,
                                output int mode, output bit nd);
      bit up;
      bit dn;
      up = any_in(p, f + 1, FL - 1);
      dn = any_in(p, 0, f - 1);
      if (d ? up : dn) begin mode = 1; nd = d; end
      else if (up || dn) begin mode = 1; nd = !d; end
      else begin mode = 0; nd = d; end
      if (f == FL - 1) nd = 1'b0;
      if (f == 0) nd = 1'b1;
   endfunction

   always @(posedge clk or posedge reset0) begin
      logic [FL-1:0] c;
      logic [FL-1:0] np;
      int nmode, nfl, ntt, ndt, no;
      bit ndir;
      if (reset0) begin
         m_pend = '0; m_floor = 0; m_dir = 1'b1; m_mode = 0;
         m_occ = 0; m_ovl = 1'b0; m_tt = 0; m_dt = 0;
      end else begin
         c = bus.call_in | bus.call_out;
         np = m_pend; nmode = m_mode; nfl = m_floor; ndir = m_dir; ntt = m_tt; ndt = m_dt;
         for (int i = 0; i < FL; i++)
            if (c[i] && !(m_mode != 1 && i == m_floor)) np[i] = 1'b1;
         no = m_occ;
         if (m_mode == 2 && bus.enter && !bus.leave) no = (m_occ < OMAX) ? m_occ + 1 : OMAX;
         if (m_mode == 2 && bus.leave && !bus.enter) no = (m_occ > 0) ? m_occ - 1 : 0;
         case (m_mode)
            0: begin
               if (m_pend[m_floor] || c[m_floor]) begin
                  nmode = 2; np[m_floor] = 1'b0; ndt = 0;
               end else begin
                  pick(m_pend, m_floor, m_dir, nmode, ndir);
                  ntt = 0;
               end
            end
            1: if (bus.tick) begin
               ntt = m_tt + 1;
               if (ntt == TT) begin
                  ntt = 0;
                  nfl = m_floor + (m_dir ? 1 : -1);
                  if (m_pend[nfl]) begin
                     nmode = 2; np[nfl] = 1'b0; ndt = 0;
                     ndir = (nfl == FL - 1) ? 1'b0 : (nfl == 0) ? 1'b1 : m_dir;
                  end else begin
                     pick(m_pend, nfl, m_dir, nmode, ndir);
                  end
               end
            end
            default: begin
               if (bus.enter || bus.leave || c[m_floor] || m_ovl) ndt = 0;
               else if (bus.tick) begin
                  ndt = m_dt + 1;
                  if (ndt == DT) begin
                     ndt = 0;
                     pick(m_pend, m_floor, m_dir, nmode, ndir);
                     ntt = 0;
                  end
               end
            end
         endcase
         m_pend = np; m_floor = nfl; m_dir = ndir; m_mode = nmode;
         m_tt = ntt; m_dt = ndt; m_occ = no; m_ovl = (no > CAP);
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("floor",     int'(bus.floor),     m_floor);
         chk("dir_up",    int'(bus.dir_up),    int'(m_dir));
         chk("moving",    int'(bus.moving),    int'(m_mode == 1));
         chk("door_open", int'(bus.door_open), int'(m_mode == 2));
         chk("pending",   int'(bus.pending),   int'(m_pend));
         chk("occupancy", int'(bus.occupancy), m_occ);
         chk("overload",  int'(bus.overload),  int'(m_ovl));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         bus.tick = 1'b1;
         @(negedge clk);
         bus.tick = 1'b0;
         cyc(2);
      end
   endtask

   task automatic press_in(input int f);
      logic [FL-1:0] v;
      v = '0;
      v[f] = 1'b1;
      bus.call_in = v;
      @(negedge clk);
      bus.call_in = '0;
   endtask

   task automatic pulse(input bit e, input bit l);
      bus.enter = e;
      bus.leave = l;
      @(negedge clk);
      bus.enter = 1'b0;
      bus.leave = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 reset0 = 1'b1;
      @(negedge clk);
      reset0 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      errors = 0; checks = 0; cmp_en = 1'b0;
      reset0 = 1'b0;
      bus.tick = 1'b0; bus.call_in = '0; bus.call_out = '0;
      bus.enter = 1'b0; bus.leave = 1'b0;
      #1 reset0 = 1'b1;
      cyc(2);
      reset0 = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);

      // Reset values, then a hall call at the parked floor opens the door.
      chk("rst_floor", int'(bus.floor), 0);
      chk("rst_dir", int'(bus.dir_up), 1);
      chk("rst_door", int'(bus.door_open), 0);
      chk("rst_pend", int'(bus.pending), 0);
      bus.call_out = 4'b0001;
      @(negedge clk);
      bus.call_out = '0;
      chk("samefl_door", int'(bus.door_open), 1);
      chk("samefl_pend", int'(bus.pending), 0);
      ticks(4);
      chk("samefl_close", int'(bus.door_open), 0);

      // Cabin call to the top floor: 9 ticks of travel, then a 4-tick door.
      press_in(3);
      cyc(1);
      chk("go3_moving", int'(bus.moving), 1);
      ticks(9);
      chk("go3_floor", int'(bus.floor), 3);
      chk("go3_door", int'(bus.door_open), 1);
      chk("go3_pend", int'(bus.pending), 0);
      ticks(3);
      chk("go3_door_hold", int'(bus.door_open), 1);
      ticks(1);
      chk("go3_closed", int'(bus.door_open), 0);
      chk("go3_idle", int'(bus.moving), 0);
      chk("go3_dir_top", int'(bus.dir_up), 0);

      // Moving up at floor 1 with requests above and below: serve 3, then reverse to 0.
      do_reset();
      press_in(3);
      cyc(1);
      ticks(3);
      chk("scan_floor1", int'(bus.floor), 1);
      press_in(0);
      chk("scan_pend", int'(bus.pending), 9);
      ticks(6);
      chk("scan_at3", int'(bus.floor), 3);
      chk("scan_pend0", int'(bus.pending), 1);
      ticks(4);
      chk("scan_rev_mv", int'(bus.moving), 1);
      chk("scan_rev_dir", int'(bus.dir_up), 0);
      ticks(9);
      chk("scan_at0", int'(bus.floor), 0);
      chk("scan_door0", int'(bus.door_open), 1);

      // Overload holds the door; one leave releases it.
      repeat (5) pulse(1'b1, 1'b0);
      chk("ovl_occ", int'(bus.occupancy), 5);
      chk("ovl_flag", int'(bus.overload), 1);
      ticks(10);
      chk("ovl_hold", int'(bus.door_open), 1);
      pulse(1'b0, 1'b1);
      chk("ovl_occ4", int'(bus.occupancy), 4);
      chk("ovl_clear", int'(bus.overload), 0);
      ticks(3);
      chk("ovl_open3", int'(bus.door_open), 1);
      ticks(1);
      chk("ovl_closed", int'(bus.door_open), 0);

      // Door-closed pulse ignored, simultaneous pulses cancel, saturation at 7.
      pulse(1'b1, 1'b0);
      chk("closed_enter", int'(bus.occupancy), 4);
      bus.call_out = 4'b0001;
      @(negedge clk);
      bus.call_out = '0;
      pulse(1'b1, 1'b1);
      chk("both_pulse", int'(bus.occupancy), 4);
      repeat (8) pulse(1'b1, 1'b0);
      chk("sat_occ", int'(bus.occupancy), 7);
      chk("sat_ovl", int'(bus.overload), 1);
      repeat (4) pulse(1'b0, 1'b1);
      chk("drain_occ", int'(bus.occupancy), 3);
      ticks(4);

      // Asynchronous reset while travelling between floors 1 and 2.
      press_in(3);
      cyc(1);
      ticks(4);
      chk("mid_pend", int'(bus.pending), 8);
      #2 reset0 = 1'b1;
      #1;
      chk("arst_floor", int'(bus.floor), 0);
      chk("arst_moving", int'(bus.moving), 0);
      chk("arst_pend", int'(bus.pending), 0);
      chk("arst_occ", int'(bus.occupancy), 0);
      @(negedge clk);
      reset0 = 1'b0;
      @(negedge clk);

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         bus.call_in  = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         bus.call_out = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         bus.enter    = ($urandom_range(0, 7) == 0);
         bus.leave    = ($urandom_range(0, 6) == 0);
         bus.tick     = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      bus.call_in = '0; bus.call_out = '0;
      bus.enter = 1'b0; bus.leave = 1'b0; bus.tick = 1'b0;
      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
